// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment scan driver.
//   SEG_OFF / AN_OFF  : all-off patterns for the active-low segment and anode buses
//   scan_state_t      : per-slot phase, BLANK (anti-ghosting gap) or DRIVE
//   hex_to_seg()      : 4-bit value to active-low {dp,g,f,e,d,c,b,a}, dp always off
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex digit to seven-segment decoder.
//   nib_i [3:0] : hex value
//   seg_o [7:0] : active-low segments {dp,g,f,e,d,c,b,a}, dp held off
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] seg_o
);

    assign seg_o = hex_to_seg(nib_i);

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for an eight-digit seven-segment display.
// Shows a 32-bit word as eight hex digits, one anode at a time, with a blank
// gap at the start of every digit slot and optional leading-zero suppression.
// The displayed word is captured only at frame boundaries (or continuously
// while disabled) so a store in the middle of a frame never tears the digits.
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   data_i : word to display, nibble i -> digit i (digit 0 rightmost)
//   en_i   : display enable; low blanks the display and restarts the scan
//   an     : active-low anode selects, bit i = digit i (registered)
//   seg    : active-low segments {dp,g,f,e,d,c,b,a} (registered)
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000,
    parameter int BLANK_LZ  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_i,
    input  logic        en_i,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      shd_q, shd_d;
    scan_state_t      state_q, state_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;

    logic             tick;
    logic [CNT_W-1:0] cnt_inc;
    logic [4:0]       nib_lsb;
    logic [3:0]       nib;
    logic [7:0]       dec_seg;
    logic             suppress;

    assign tick    = (cnt_q == CNT_LAST);
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign nib_lsb = {idx_q, 2'b00};
    assign nib     = shd_q[nib_lsb +: 4];

    // A digit above 0 is a leading zero when it and every digit to its left are 0.
    assign suppress = (BLANK_LZ != 0) && (idx_q != 3'd0) && ((shd_q >> nib_lsb) == 32'd0);

    seg7_hex_decode u_dec (
        .nib_i (nib),
        .seg_o (dec_seg)
    );

    // Prescaler, digit index and shadow register.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        shd_d = shd_q;
        if (!en_i) begin
            // Disable wins over a coincident frame tick.
            cnt_d = '0;
            idx_d = 3'd0;
            shd_d = data_i;
        end else if (tick) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
                shd_d = data_i;
            end
        end else begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= 3'd0;
            shd_q <= 32'd0;
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            shd_q <= shd_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: every slot opens blank and switches to drive once the
    // prescaler reaches BLANK_CYC.
    always_comb begin
        state_d = state_q;
        if (!en_i || tick) begin
            state_d = BLANK;
        end else if (state_q == BLANK && cnt_inc == CNT_BLANK) begin
            state_d = DRIVE;
        end
    end

    // FSM outputs, registered one cycle later. en_i gates directly so a
    // disable blanks the display on the very next edge.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if (en_i && state_q == DRIVE && !suppress) begin
            an_d  = ~(8'd1 << idx_q);
            seg_d = dec_seg;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seg7_scan.sv
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_i = 1'b0;
    logic [31:0] data_i = 32'h1234_5678;
    logic [7:0]  an, seg, an_n, seg_n;

    int n_chk = 0;
    int n_bad = 0;

    logic [7:0] an_tab [8]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] s_1234 [8]  = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};

    always #5 clk = ~clk;

    seg7_scan #(.SCAN_DIV(4), .BLANK_CYC(1), .BLANK_LZ(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .data_i (data_i),
        .en_i   (en_i),
        .an     (an),
        .seg    (seg)
    );

    seg7_scan #(.SCAN_DIV(4), .BLANK_CYC(1), .BLANK_LZ(0)) dut_nlz (
        .clk    (clk),
        .rst    (rst),
        .data_i (data_i),
        .en_i   (en_i),
        .an     (an_n),
        .seg    (seg_n)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Latch v through one disabled cycle, then enable scanning from digit 0.
    task automatic start(input logic [31:0] v);
        en_i   = 1'b0;
        data_i = v;
        step();
        chk("dis_an", an, 8'hFF);
        chk("dis_seg", seg, 8'hFF);
        en_i = 1'b1;
    endtask

    // One slot: a blank cycle then three drive cycles, checked on both DUTs.
    task automatic slot(input string tag, input logic [7:0] ea, input logic [7:0] es,
                        input logic [7:0] ean, input logic [7:0] esn);
        step();
        chk({tag, "_blank_an"}, an, 8'hFF);
        chk({tag, "_blank_seg"}, seg, 8'hFF);
        chk({tag, "_blank_an_nlz"}, an_n, 8'hFF);
        for (int k = 0; k < 3; k++) begin
            step();
            chk({tag, "_an"}, an, ea);
            chk({tag, "_seg"}, seg, es);
            chk({tag, "_an_nlz"}, an_n, ean);
            chk({tag, "_seg_nlz"}, seg_n, esn);
        end
    endtask

    initial begin
        // Reset takes effect with no clock edge.
        #1 rst = 1'b1;
        #2;
        chk("rst_an", an, 8'hFF);
        chk("rst_seg", seg, 8'hFF);
        step();
        step();
        chk("rst_hold_an", an, 8'hFF);
        rst = 1'b0;

        // Full frame of 12345678.
        start(32'h1234_5678);
        for (int d = 0; d < 8; d++) begin
            slot($sformatf("frm_d%0d", d), an_tab[d], s_1234[d], an_tab[d], s_1234[d]);
        end

        // Leading-zero blanking of 000000A5.
        start(32'h0000_00A5);
        slot("lz_d0", 8'hFE, 8'h92, 8'hFE, 8'h92);
        slot("lz_d1", 8'hFD, 8'h88, 8'hFD, 8'h88);
        for (int d = 2; d < 8; d++) begin
            slot($sformatf("lz_d%0d", d), 8'hFF, 8'hFF, an_tab[d], 8'hC0);
        end

        // Zero value: only digit 0 lit with leading-zero suppression.
        start(32'h0);
        slot("zero_d0", 8'hFE, 8'hC0, 8'hFE, 8'hC0);
        for (int d = 1; d < 8; d++) begin
            slot($sformatf("zero_d%0d", d), 8'hFF, 8'hFF, an_tab[d], 8'hC0);
        end

        // Tear-free update: new data arrives in the digit-3 slot.
        start(32'h1111_1111);
        for (int d = 0; d < 3; d++) begin
            slot($sformatf("tear_d%0d", d), an_tab[d], 8'hF9, an_tab[d], 8'hF9);
        end
        data_i = 32'h2222_2222;
        for (int d = 3; d < 8; d++) begin
            slot($sformatf("tear_d%0d", d), an_tab[d], 8'hF9, an_tab[d], 8'hF9);
        end
        slot("tear_next_d0", 8'hFE, 8'hA4, 8'hFE, 8'hA4);

        // Enable dropped mid-drive (digit 1), then re-enabled.
        step();
        step();
        chk("en_pre_an", an, 8'hFD);
        chk("en_pre_seg", seg, 8'hA4);
        en_i = 1'b0;
        step();
        chk("en_off_an", an, 8'hFF);
        chk("en_off_seg", seg, 8'hFF);
        en_i = 1'b1;
        step();
        chk("en_re_blank_an", an, 8'hFF);
        step();
        chk("en_re_an", an, 8'hFE);
        chk("en_re_seg", seg, 8'hA4);

        // Asynchronous reset between edges while driving.
        #3 rst = 1'b1;
        #1;
        chk("arst_an", an, 8'hFF);
        chk("arst_seg", seg, 8'hFF);
        chk("arst_an_nlz", an_n, 8'hFF);
        step();
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
